// File: rtl/pcileech_rmii_tx.sv
// pcileech_rmii_tx: RMII transmit framer. Serialises one Ethernet frame with
// preamble/SFD, zero padding to the minimum length, CRC-32 FCS and IFG.
module pcileech_rmii_tx #(
  parameter int PARAM_PREAMBLE_BYTES = 7,
  parameter int PARAM_MIN_FRAME      = 60,
  parameter int PARAM_IFG_BYTES      = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       eth_tx_en,
  output logic [1:0] eth_tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_underrun
);

  localparam logic [7:0]  IFG_FULL = 8'(PARAM_IFG_BYTES * 4);
  localparam logic [7:0]  IFG_LOAD = 8'(PARAM_IFG_BYTES * 4 - 1);
  localparam logic [7:0]  PRE_LAST = 8'(PARAM_PREAMBLE_BYTES - 1);
  localparam logic [11:0] MIN_CNT  = 12'(PARAM_MIN_FRAME);
  localparam logic [11:0] MIN_M1   = 12'(PARAM_MIN_FRAME - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_SFD      = 3'd2,
    S_DATA     = 3'd3,
    S_PAD      = 3'd4,
    S_FCS      = 3'd5,
    S_IFG      = 3'd6
  } state_t;

  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] v;
    v = c;
    for (int i = 0; i < 2; i++) begin
      if (v[0] ^ d[i]) v = (v >> 1) ^ 32'hEDB88320;
      else             v = v >> 1;
    end
    return v;
  endfunction

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  state_t      r_state, w_state;
  logic [1:0]  r_dibit, w_dibit;
  logic [7:0]  r_cnt, w_cnt;
  logic [11:0] r_byte_cnt, w_byte_cnt;
  logic [7:0]  r_sh, w_sh;
  logic [7:0]  r_nxt, w_nxt;
  logic        r_nxt_last, w_nxt_last;
  logic        r_pend, w_pend;
  logic [31:0] r_crc, w_crc;
  logic        r_s_ready, w_s_ready;
  logic        r_tx_en, w_tx_en;
  logic [1:0]  r_tx_data, w_tx_data;
  logic        r_tx_busy, w_busy;
  logic        r_tx_done, w_done;
  logic        r_tx_underrun, w_underrun;

  // r_nxt holds one prefetched byte; r_sh is the byte currently on the wire.
  always_comb begin
    w_state    = r_state;
    w_dibit    = r_dibit + 2'd1;
    w_cnt      = r_cnt;
    w_byte_cnt = r_byte_cnt;
    w_sh       = r_sh;
    w_nxt      = r_nxt;
    w_nxt_last = r_nxt_last;
    w_pend     = r_pend;
    w_crc      = r_crc;
    w_underrun = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_dibit = 2'd0;
        if (s_valid && r_s_ready) begin
          w_nxt      = s_data;
          w_nxt_last = s_last;
          w_pend     = 1'b1;
          w_byte_cnt = 12'd1;
          w_crc      = 32'hFFFFFFFF;
          w_cnt      = 8'd0;
          w_state    = S_PREAMBLE;
        end else begin
          w_state = S_IDLE;
        end
      end
      S_PREAMBLE: begin
        if (r_dibit == 2'd3) begin
          if (r_cnt == PRE_LAST) w_state = S_SFD;
          else                   w_cnt = r_cnt + 8'd1;
        end else begin
          w_state = S_PREAMBLE;
        end
      end
      S_SFD, S_DATA: begin
        if (r_state == S_DATA) w_crc = crc_dibit(r_crc, r_tx_data);
        else                   w_crc = r_crc;
        if (r_dibit != 2'd3) begin
          w_state = r_state;
        end else if (r_pend) begin
          w_sh    = r_nxt;
          w_state = S_DATA;
          if (!r_nxt_last) begin
            if (s_valid) begin
              w_nxt      = s_data;
              w_nxt_last = s_last;
              w_byte_cnt = sat_inc(r_byte_cnt);
            end else begin
              w_underrun = 1'b1;
              w_state    = S_IFG;
              w_cnt      = IFG_LOAD;
            end
          end else begin
            w_pend = 1'b0;
          end
        end else if (r_byte_cnt < MIN_CNT) begin
          w_state = S_PAD;
        end else begin
          w_state = S_FCS;
          w_cnt   = 8'd0;
        end
      end
      S_PAD: begin
        w_crc = crc_dibit(r_crc, r_tx_data);
        if (r_dibit == 2'd3) begin
          w_byte_cnt = sat_inc(r_byte_cnt);
          if (r_byte_cnt >= MIN_M1) begin
            w_state = S_FCS;
            w_cnt   = 8'd0;
          end else begin
            w_state = S_PAD;
          end
        end else begin
          w_state = S_PAD;
        end
      end
      S_FCS: begin
        w_crc = r_crc >> 2;
        if (r_cnt == 8'd15) begin
          w_state = S_IFG;
          w_cnt   = IFG_LOAD;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end
      S_IFG: begin
        w_dibit = 2'd0;
        if (r_cnt <= 8'd1) w_state = S_IDLE;
        else               w_cnt = r_cnt - 8'd1;
      end
      default: begin
        w_state = S_IFG;
        w_cnt   = IFG_FULL;
        w_dibit = 2'd0;
      end
    endcase
  end

  // Registered outputs are derived from the next-cycle state.
  always_comb begin
    w_tx_en   = 1'b0;
    w_tx_data = 2'b00;
    case (w_state)
      S_PREAMBLE: begin
        w_tx_en   = 1'b1;
        w_tx_data = 2'b01;
      end
      S_SFD: begin
        w_tx_en   = 1'b1;
        w_tx_data = (w_dibit == 2'd3) ? 2'b11 : 2'b01;
      end
      S_DATA: begin
        w_tx_en = 1'b1;
        case (w_dibit)
          2'd0:    w_tx_data = w_sh[1:0];
          2'd1:    w_tx_data = w_sh[3:2];
          2'd2:    w_tx_data = w_sh[5:4];
          default: w_tx_data = w_sh[7:6];
        endcase
      end
      S_PAD: begin
        w_tx_en   = 1'b1;
        w_tx_data = 2'b00;
      end
      S_FCS: begin
        w_tx_en   = 1'b1;
        w_tx_data = ~w_crc[1:0];
      end
      default: begin
        w_tx_en   = 1'b0;
        w_tx_data = 2'b00;
      end
    endcase
    w_s_ready = (w_state == S_IDLE) ||
                (((w_state == S_SFD) || (w_state == S_DATA)) &&
                 (w_dibit == 2'd3) && w_pend && !w_nxt_last);
    // The gap that follows reset is not part of a frame, so busy holds its value.
    if ((r_state == S_IFG) && (w_state == S_IFG)) w_busy = r_tx_busy;
    else                                          w_busy = (w_state != S_IDLE);
    w_done = (r_state == S_FCS) && (w_state == S_IFG);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IFG;
      r_dibit       <= 2'd0;
      r_cnt         <= IFG_FULL;
      r_byte_cnt    <= 12'd0;
      r_sh          <= 8'd0;
      r_nxt         <= 8'd0;
      r_nxt_last    <= 1'b0;
      r_pend        <= 1'b0;
      r_crc         <= 32'hFFFFFFFF;
      r_s_ready     <= 1'b0;
      r_tx_en       <= 1'b0;
      r_tx_data     <= 2'b00;
      r_tx_busy     <= 1'b0;
      r_tx_done     <= 1'b0;
      r_tx_underrun <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_dibit       <= w_dibit;
      r_cnt         <= w_cnt;
      r_byte_cnt    <= w_byte_cnt;
      r_sh          <= w_sh;
      r_nxt         <= w_nxt;
      r_nxt_last    <= w_nxt_last;
      r_pend        <= w_pend;
      r_crc         <= w_crc;
      r_s_ready     <= w_s_ready;
      r_tx_en       <= w_tx_en;
      r_tx_data     <= w_tx_data;
      r_tx_busy     <= w_busy;
      r_tx_done     <= w_done;
      r_tx_underrun <= w_underrun;
    end
  end

  assign s_ready     = r_s_ready;
  assign eth_tx_en   = r_tx_en;
  assign eth_tx_data = r_tx_data;
  assign tx_busy     = r_tx_busy;
  assign tx_done     = r_tx_done;
  assign tx_underrun = r_tx_underrun;

endmodule

// File: tb/tb_pcileech_rmii_tx.sv
// tb_pcileech_rmii_tx: random frames checked against a byte-level frame model
// (preamble, SFD, padded payload, bytewise CRC-32 FCS) decoded from the RMII wire.
module tb_pcileech_rmii_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_data = 8'd0;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       s_ready, eth_tx_en, tx_busy, tx_done, tx_underrun;
  logic [1:0] eth_tx_data;

  pcileech_rmii_tx dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .eth_tx_en(eth_tx_en), .eth_tx_data(eth_tx_data),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_underrun(tx_underrun)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wire monitor: records every TX_EN-high dibit, burst lengths, gaps and pulses.
  logic [1:0] mon_q[$];
  int len_q[$];
  int gap_q[$];
  int gap_rdy_q[$];
  int run = 0, gap = 0, gap_rdy = 0, cyc = 0;
  bit prev_en = 1'b0, seen_fall = 1'b0;
  int done_cnt = 0, und_cnt = 0, done_cyc = -1, und_cyc = -1, fall_cyc = -1;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (tx_done) begin done_cnt++; done_cyc = cyc; end
    if (tx_underrun) begin und_cnt++; und_cyc = cyc; end
    if (eth_tx_en) begin
      if (!prev_en && seen_fall) begin
        gap_q.push_back(gap);
        gap_rdy_q.push_back(gap_rdy);
      end
      mon_q.push_back(eth_tx_data);
      run++;
    end else begin
      if (prev_en) begin
        len_q.push_back(run);
        run = 0; gap = 0; gap_rdy = 0;
        seen_fall = 1'b1;
        fall_cyc = cyc;
      end
      if (seen_fall) begin
        if (s_ready && gap < 47) gap_rdy++;
        gap++;
      end
    end
    prev_en = eth_tx_en;
  end

  int rd_len = 0;
  int rd_dib = 0;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] v;
    v = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++) v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
    return v;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int k = 0; k < 32; k++) r[k] = v[31-k];
    return r;
  endfunction

  // Reference: full frame as dibits, bytes padded to 60 and followed by ~CRC LSB first.
  task automatic build_dibits(input logic [7:0] pl[$], output logic [1:0] dq[$]);
    logic [7:0] fr[$];
    logic [7:0] body[$];
    logic [7:0] b;
    logic [31:0] c;
    fr = {};
    body = pl;
    dq = {};
    for (int i = 0; i < 7; i++) fr.push_back(8'h55);
    fr.push_back(8'hD5);
    while (body.size() < 60) body.push_back(8'h00);
    c = 32'hFFFFFFFF;
    foreach (body[i]) begin
      c = crc_byte(c, body[i]);
      fr.push_back(body[i]);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) fr.push_back(c[8*i +: 8]);
    foreach (fr[i]) begin
      b = fr[i];
      for (int k = 0; k < 4; k++) dq.push_back(b[2*k +: 2]);
    end
  endtask

  task automatic wait_len(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      if (len_q.size() > rd_len) begin ok = 1'b1; break; end
      @(posedge clk); #2;
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] pl[$]);
    logic [1:0] exp_q[$];
    logic [7:0] cb[$];
    logic [7:0] b;
    logic [1:0] d;
    logic [31:0] c;
    bit ok;
    int len, errs;
    build_dibits(pl, exp_q);
    wait_len(ok);
    if (!ok) begin
      check_eq({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    len = len_q[rd_len];
    rd_len++;
    check_eq({tag, "_txen_cycles"}, len, exp_q.size());
    errs = 0;
    cb = {};
    b = 8'd0;
    for (int i = 0; i < len; i++) begin
      d = mon_q[rd_dib + i];
      if (i >= exp_q.size() || d !== exp_q[i]) errs++;
      b[2*(i%4) +: 2] = d;
      if (i % 4 == 3) cb.push_back(b);
    end
    rd_dib += len;
    check_eq({tag, "_dibit_errors"}, errs, 32'd0);
    c = 32'hFFFFFFFF;
    for (int j = 8; j < cb.size(); j++) c = crc_byte(c, cb[j]);
    check_eq({tag, "_residue"}, bitrev32(c), 32'hC704DD7B);
  endtask

  task automatic send_frame(input logic [7:0] pl[$], input bit trunc);
    bit got;
    for (int i = 0; i < pl.size(); i++) begin
      s_data  = pl[i];
      s_last  = !trunc && (i == pl.size() - 1);
      s_valid = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 4000; t++) begin
        @(negedge clk);
        if (s_ready) begin got = 1'b1; break; end
      end
      if (!got) begin
        check_eq("send_ready_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic check_ready_after_reset(input string tag);
    int n;
    n = 0;
    for (int t = 0; t < 200; t++) begin
      @(posedge clk); #2;
      n++;
      if (s_ready) break;
    end
    check_eq(tag, n, 32'd48);
  endtask

  task automatic rand_payload(input int n, output logic [7:0] pl[$]);
    pl = {};
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    logic [7:0] pl[$];
    logic [7:0] pb[$];
    logic [1:0] exp_q[$];
    logic [31:0] c;
    bit ok;
    int base_done, base_und, len, errs;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_tx_en", eth_tx_en, 32'd0);
    check_eq("rst_tx_data", eth_tx_data, 32'd0);
    check_eq("rst_s_ready", s_ready, 32'd0);
    check_eq("rst_tx_busy", tx_busy, 32'd0);
    check_eq("rst_tx_done", tx_done, 32'd0);
    check_eq("rst_tx_underrun", tx_underrun, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_ready_after_reset("rst_release_to_ready");

    base_done = done_cnt;
    base_und = und_cnt;
    rand_payload(64, pl);
    send_frame(pl, 1'b0);
    check_frame("f64", pl);
    check_eq("f64_busy_in_ifg", tx_busy, 32'd1);
    check_eq("f64_done_pulses", done_cnt - base_done, 32'd1);
    check_eq("f64_done_at_txen_fall", done_cyc, fall_cyc);
    check_eq("f64_no_underrun", und_cnt - base_und, 32'd0);
    repeat (60) @(posedge clk);
    #2;
    check_eq("idle_busy_low", tx_busy, 32'd0);
    check_eq("idle_ready_high", s_ready, 32'd1);

    pl = {8'hAB};
    send_frame(pl, 1'b0);
    check_frame("f1", pl);

    pl = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    c = 32'hFFFFFFFF;
    foreach (pl[i]) c = crc_byte(c, pl[i]);
    check_eq("model_crc_123456789", ~c, 32'hCBF43926);
    send_frame(pl, 1'b0);
    check_frame("f9", pl);

    rand_payload(60, pl);
    rand_payload(60, pb);
    send_frame(pl, 1'b0);
    send_frame(pb, 1'b0);
    check_frame("b2b_a", pl);
    check_frame("b2b_b", pb);
    if (gap_q.size() > 0) begin
      check_eq("b2b_gap_cycles", gap_q[gap_q.size()-1], 32'd48);
      check_eq("b2b_ready_in_gap", gap_rdy_q[gap_rdy_q.size()-1], 32'd0);
    end else begin
      check_eq("b2b_gap_recorded", 32'd0, 32'd1);
    end

    for (int k = 0; k < 6; k++) begin
      rand_payload($urandom_range(1, 100), pl);
      repeat ($urandom_range(0, 20)) @(posedge clk);
      #1;
      send_frame(pl, 1'b0);
      check_frame($sformatf("rnd%0d", k), pl);
    end

    base_done = done_cnt;
    base_und = und_cnt;
    rand_payload(9, pl);
    send_frame(pl, 1'b1);
    for (int t = 0; t < 500; t++) begin
      if (und_cnt > base_und) break;
      @(posedge clk); #2;
    end
    check_eq("und_pulses", und_cnt - base_und, 32'd1);
    wait_len(ok);
    if (ok) begin
      build_dibits(pl, exp_q);
      len = len_q[rd_len];
      rd_len++;
      check_eq("und_txen_cycles", len, 32'd64);
      errs = 0;
      for (int i = 0; i < len; i++) if (mon_q[rd_dib + i] !== exp_q[i]) errs++;
      rd_dib += len;
      check_eq("und_dibit_errors", errs, 32'd0);
      check_eq("und_txen_drop_cycle", fall_cyc, und_cyc);
    end else begin
      check_eq("und_timeout", 32'd0, 32'd1);
    end
    check_eq("und_no_done", done_cnt - base_done, 32'd0);
    rand_payload(20, pb);
    send_frame(pb, 1'b0);
    check_frame("after_und", pb);
    check_eq("und_gap_cycles", gap_q[gap_q.size()-1], 32'd48);

    base_done = done_cnt;
    rand_payload(5, pl);
    send_frame(pl, 1'b0);
    repeat (60) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("prst_txen_async", eth_tx_en, 32'd0);
    check_eq("prst_ready_async", s_ready, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_ready_after_reset("prst_release_to_ready");
    check_eq("prst_no_done", done_cnt - base_done, 32'd0);
    if (len_q.size() > rd_len) begin
      rd_dib += len_q[rd_len];
      rd_len++;
    end
    rand_payload(30, pl);
    send_frame(pl, 1'b0);
    check_frame("after_prst", pl);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
